// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the MEM-stage load/store port. It accepts one word
// read or write per request, holds the pipeline with stall_o for LATENCY
// cycles, and then completes with a one-cycle ack_o. For a load, data_o is
// valid during ack_o, in time for the MEM/WB register.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two, >= 4)
//   LATENCY  cycles from request acceptance to response (1..15)
//
// Ports
//   clk_i       clock
//   rst_i       asynchronous active-high reset
//   MemRead_i   load request
//   MemWrite_i  store request (a store wins if both requests are set)
//   addr_i      byte address; the word index is addr_i[AW+1:2]
//   data_i      store data
//   data_o      load data, valid while ack_o=1, otherwise holds its value
//   stall_o     pipeline freeze (combinational)
//   ack_o       request completes this cycle
//   err_o       request rejected, valid with ack_o
//
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject misaligned or
// out-of-range addresses. A rejected request still completes with normal
// timing. It does not write memory and does not update data_o. When the macro
// is undefined, err_o is tied 0 and addresses alias modulo DEPTH*4.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic            write_reg, write_next;
    logic [AW-1:0]   index_reg, index_next;
    logic [31:0]     wdata_reg, wdata_next;
    logic            bad_reg, bad_next;
    logic            ack_next;
    logic            req;
    logic            addr_bad;
    logic            rd_en;
    logic            wr_en;

    logic [31:0]     mem [DEPTH];

    assign req = MemRead_i | MemWrite_i;

`ifdef DMEM_ALIGN_CHECK_EN
    assign addr_bad = (addr_i[1:0] != 2'b00) || (addr_i >= 32'(DEPTH * 4));
`else
    // Address bits outside the word index are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:AW+2], addr_i[1:0]};
    assign addr_bad = 1'b0;
`endif

    // Next-state and stall logic. The request context is captured only in IDLE.
    // In BUSY and RESP the context is frozen, so the request that the pipeline
    // still holds during RESP is not accepted a second time.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        write_next = write_reg;
        index_next = index_reg;
        wdata_next = wdata_reg;
        bad_next   = bad_reg;
        stall_o    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    stall_o    = 1'b1;
                    write_next = MemWrite_i;
                    index_next = addr_i[AW+1:2];
                    wdata_next = data_i;
                    bad_next   = addr_bad;
                    cnt_next   = 4'(LATENCY - 1);
                    state_next = (cnt_next == 4'd0) ? RESP : BUSY;
                end
            end
            BUSY: begin
                stall_o    = 1'b1;
                cnt_next   = cnt_reg - 4'd1;
                if (cnt_next == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The read happens on the edge that enters RESP, so data_o is already
    // valid in the ack cycle. index_next holds the index from addr_i when the
    // FSM goes straight from IDLE to RESP, and the latched index otherwise.
    assign rd_en    = (state_next == RESP) && (state_reg != RESP) && !write_next && !bad_next;
    assign wr_en    = (state_reg == RESP) && write_reg && !bad_reg;
    assign ack_next = (state_next == RESP);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            write_reg <= 1'b0;
            index_reg <= '0;
            wdata_reg <= 32'd0;
            bad_reg   <= 1'b0;
            ack_o     <= 1'b0;
            data_o    <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            write_reg <= write_next;
            index_reg <= index_next;
            wdata_reg <= wdata_next;
            bad_reg   <= bad_next;
            ack_o     <= ack_next;
            if (rd_en) begin
                data_o <= mem[index_next];
            end
        end
    end

    // The storage array has no reset. A write commits on the edge that leaves
    // RESP. A reset that lands in BUSY or RESP forces the FSM out of RESP
    // before that edge, so the pending write is dropped.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[index_reg] <= wdata_reg;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic err_reg;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= ack_next && bad_next;
        end
    end
    assign err_o = err_reg;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Bench for dmem_responder. It instantiates two units: unit 0 with LATENCY=2
// and unit 1 with LATENCY=1. Directed vectors come from a table. Reset,
// back-to-back and mid-operation reset cases are hand-written sequences. A
// randomized run is checked against a word-array reference model. The
// expectations follow DMEM_ALIGN_CHECK_EN when the macro is defined.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT0  = 2;
    localparam int LAT1  = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mr [2];
    logic        mw [2];
    logic [31:0] ad [2];
    logic [31:0] di [2];
    logic [31:0] dq [2];
    logic        st [2];
    logic        ak [2];
    logic        er [2];

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    logic [31:0] mmem  [2][DEPTH];
    logic [31:0] mdout [2];

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) u0 (
        .clk_i(clk), .rst_i(rst), .MemRead_i(mr[0]), .MemWrite_i(mw[0]),
        .addr_i(ad[0]), .data_i(di[0]), .data_o(dq[0]), .stall_o(st[0]),
        .ack_o(ak[0]), .err_o(er[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) u1 (
        .clk_i(clk), .rst_i(rst), .MemRead_i(mr[1]), .MemWrite_i(mw[1]),
        .addr_i(ad[1]), .data_i(di[1]), .data_o(dq[1]), .stall_o(st[1]),
        .ack_o(ak[1]), .err_o(er[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic bit model_err(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
`else
        return (a === 32'hxxxx_xxxx);  // never true for a driven address
`endif
    endfunction

    // The model works at word level: the index is the address divided by 4,
    // modulo DEPTH. A write updates the array, and a read updates the
    // returned value. Erroring requests change nothing.
    task automatic model_apply(input int u, input bit wr, input logic [31:0] a,
                               input logic [31:0] d, output logic [31:0] edout,
                               output bit eerr);
        int idx;
        idx  = int'((a / 4) % DEPTH);
        eerr = model_err(a);
        if (!eerr) begin
            if (wr) mmem[u][idx] = d;
            else    mdout[u]     = mmem[u][idx];
        end
        edout = mdout[u];
    endtask

    // Call this 1 time unit after a rising edge. It holds the request until
    // the ack cycle has ended, as a stalled pipeline would, and it checks the
    // stall and ack timing along the way.
    task automatic do_req(input int u, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] dout,
                          output logic errv, output int ack_at);
        int lat;
        int stalls;
        bit seen;
        lat    = (u == 0) ? LAT0 : LAT1;
        stalls = 0;
        seen   = 1'b0;
        dout   = '0;
        errv   = 1'b0;
        ack_at = -1;
        mr[u] = rd; mw[u] = wr; ad[u] = a; di[u] = d;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (ak[u] === 1'b1) begin
                seen   = 1'b1;
                dout   = dq[u];
                errv   = er[u];
                ack_at = cyc;
                chk("ack_latency", 32'(c), 32'(lat));
                chk("stall_in_resp", {31'd0, st[u]}, 32'd0);
            end else if (st[u] === 1'b1) begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        mr[u] = 1'b0; mw[u] = 1'b0;
        chk("ack_seen", {31'd0, seen}, 32'd1);
        chk("stall_cycles", 32'(stalls), 32'(lat));
        $display("txn u=%0d rd=%0d wr=%0d addr=%h wdata=%h ack_cyc=%0d dout=%h err=%0d",
                 u, rd, wr, a, d, ack_at, dout, errv);
    endtask

    task automatic idle_check(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                chk("idle_stall", {31'd0, st[u]}, 32'd0);
                chk("idle_ack", {31'd0, ak[u]}, 32'd0);
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] edout;
        bit          eerr;
    } vec_t;

    vec_t        tbl [10];
    logic [31:0] dout, mexp, t0d;
    logic        errv;
    bit          merr;
    int          t_ack, t1, t2;
    bit          found;

    initial begin
        for (int u = 0; u < 2; u++) begin
            mr[u] = 1'b0; mw[u] = 1'b0; ad[u] = '0; di[u] = '0;
            mdout[u] = '0;
            for (int i = 0; i < DEPTH; i++) mmem[u][i] = '0;
        end

        // Directed vectors for unit 0, applied back-to-back.
        tbl[0] = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 32'h8,   32'h55,       32'hDEADBEEF, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 32'h8,   32'h0,        32'h55,       1'b0};
        tbl[4] = '{1'b0, 1'b1, 32'h0,   32'h9,        32'h55,       1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
        tbl[5] = '{1'b0, 1'b1, 32'h400, 32'h7,        32'h55,       1'b1};
        tbl[6] = '{1'b1, 1'b0, 32'h0,   32'h0,        32'h9,        1'b0};
        tbl[7] = '{1'b0, 1'b1, 32'h402, 32'hAA,       32'h9,        1'b1};
        tbl[8] = '{1'b1, 1'b0, 32'h0,   32'h0,        32'h9,        1'b0};
        tbl[9] = '{1'b1, 1'b0, 32'h3,   32'h0,        32'h9,        1'b1};
`else
        tbl[5] = '{1'b0, 1'b1, 32'h400, 32'h7,        32'h55,       1'b0};
        tbl[6] = '{1'b1, 1'b0, 32'h0,   32'h0,        32'h7,        1'b0};
        tbl[7] = '{1'b0, 1'b1, 32'h402, 32'hAA,       32'h7,        1'b0};
        tbl[8] = '{1'b1, 1'b0, 32'h0,   32'h0,        32'hAA,       1'b0};
        tbl[9] = '{1'b1, 1'b0, 32'h3,   32'h0,        32'hAA,       1'b0};
`endif

        // Reset pulse, then five quiet cycles.
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                chk("rst_stall", {31'd0, st[u]}, 32'd0);
                chk("rst_ack", {31'd0, ak[u]}, 32'd0);
                chk("rst_dout", dq[u], 32'd0);
                chk("rst_err", {31'd0, er[u]}, 32'd0);
            end
            @(posedge clk); #1;
        end

        // Table-driven directed vectors.
        for (int i = 0; i < 10; i++) begin
            do_req(0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, dout, errv, t_ack);
            model_apply(0, tbl[i].wr, tbl[i].a, tbl[i].d, mexp, merr);
            chk("tbl_dout", dout, tbl[i].edout);
            chk("tbl_err", {31'd0, errv}, {31'd0, tbl[i].eerr});
        end
        idle_check(2);

        // LATENCY=1: back-to-back reads, with acks two cycles apart.
        do_req(1, 1'b0, 1'b1, 32'h0, 32'h1, dout, errv, t_ack);
        model_apply(1, 1'b1, 32'h0, 32'h1, mexp, merr);
        do_req(1, 1'b0, 1'b1, 32'h4, 32'h2, dout, errv, t_ack);
        model_apply(1, 1'b1, 32'h4, 32'h2, mexp, merr);
        do_req(1, 1'b1, 1'b0, 32'h0, 32'h0, dout, errv, t1);
        model_apply(1, 1'b0, 32'h0, 32'h0, mexp, merr);
        chk("b2b_first", dout, 32'h1);
        do_req(1, 1'b1, 1'b0, 32'h4, 32'h0, dout, errv, t2);
        model_apply(1, 1'b0, 32'h4, 32'h0, mexp, merr);
        chk("b2b_second", dout, 32'h2);
        chk("b2b_spacing", 32'(t2 - t1), 32'd2);
        idle_check(2);

        // Reset asserted in BUSY of a write; the old value must survive.
        do_req(0, 1'b0, 1'b1, 32'hC, 32'h9, dout, errv, t_ack);
        model_apply(0, 1'b1, 32'hC, 32'h9, mexp, merr);
        t0d = dq[0];
        mw[0] = 1'b1; ad[0] = 32'hC; di[0] = 32'h1234;
        @(negedge clk);
        chk("midrst_stall_c0", {31'd0, st[0]}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_stall_busy", {31'd0, st[0]}, 32'd1);
        chk("midrst_ack_busy", {31'd0, ak[0]}, 32'd0);
        chk("midrst_dout_busy", dq[0], t0d);
        mw[0] = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_stall", {31'd0, st[0]}, 32'd0);
        chk("midrst_ack", {31'd0, ak[0]}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        mdout[0] = '0; mdout[1] = '0;
        do_req(0, 1'b1, 1'b0, 32'hC, 32'h0, dout, errv, t_ack);
        model_apply(0, 1'b0, 32'hC, 32'h0, mexp, merr);
        chk("midrst_readback", dout, 32'h9);

        // Reset asserted in RESP: ack_o must fall at once, with no write.
        mw[0] = 1'b1; ad[0] = 32'hC; di[0] = 32'h5678;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (ak[0] === 1'b1) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("resp_reached", {31'd0, found}, 32'd1);
        mw[0] = 1'b0;
        rst = 1'b1;
        #1;
        chk("resp_ack_async", {31'd0, ak[0]}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        mdout[0] = '0; mdout[1] = '0;
        do_req(0, 1'b1, 1'b0, 32'hC, 32'h0, dout, errv, t_ack);
        model_apply(0, 1'b0, 32'hC, 32'h0, mexp, merr);
        chk("resp_rst_readback", dout, 32'h9);

        // Preload every word of unit 0, then run random traffic against the model.
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] pd;
            pd = $urandom;
            do_req(0, 1'b0, 1'b1, 32'(i * 4), pd, dout, errv, t_ack);
            model_apply(0, 1'b1, 32'(i * 4), pd, mexp, merr);
        end
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ra, rd_data;
            bit rrd, rwr;
            ra = 32'($urandom_range(0, DEPTH * 8 - 1));
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            rd_data = $urandom;
            rwr = ($urandom_range(0, 1) == 1);
            rrd = !rwr || ($urandom_range(0, 3) == 0);
            model_apply(0, rwr, ra, rd_data, mexp, merr);
            do_req(0, rrd, rwr, ra, rd_data, dout, errv, t_ack);
            chk("rand_dout", dout, mexp);
            chk("rand_err", {31'd0, errv}, {31'd0, merr});
            idle_check($urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
